// File: rtl/control_unit.sv
// control_unit: hardwired Mini SRC sequencer, fetch plus per-opcode execute steps.
module control_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_contents,
  input  logic        CON_output,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        R_out,
  output logic        BAout,
  output logic        MDR_rd,
  output logic        MAR_rd,
  output logic        HI_rd,
  output logic        LO_rd,
  output logic        Z_rd,
  output logic        PC_rd,
  output logic        Out_rd,
  output logic        Y_rd,
  output logic        IR_rd,
  output logic        CONin,
  output logic        R15_rd,
  output logic        MDR_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        PC_out,
  output logic        Inport_out,
  output logic        C_out,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        reset_div,
  output logic [12:0] op_sel,
  output logic        run
);
  localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_T7 = 4'd8, S_DIV = 4'd9, S_HALT = 4'd10;
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [3:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] op;
  logic [3:0] alu_idx;
  logic [12:0] alu_sel;
  logic is_alu, is_imm, is_ld, is_ldi, is_st, is_mul, is_div, is_neg, is_not;
  logic is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt, is_multi;
  logic div_last, unused_ir;
  assign op        = IR_contents[31:27];
  assign unused_ir = ^IR_contents[26:0];
  assign is_alu  = op >= 5'd3 && op <= 5'd10;
  assign is_imm  = op >= 5'd11 && op <= 5'd13;
  assign is_ld   = op == 5'd0;
  assign is_ldi  = op == 5'd1;
  assign is_st   = op == 5'd2;
  assign is_mul  = op == 5'd14;
  assign is_div  = op == 5'd15;
  assign is_neg  = op == 5'd16;
  assign is_not  = op == 5'd17;
  assign is_br   = op == 5'd18;
  assign is_jr   = op == 5'd19;
  assign is_jal  = op == 5'd20;
  assign is_in   = op == 5'd21;
  assign is_out  = op == 5'd22;
  assign is_mfhi = op == 5'd23;
  assign is_mflo = op == 5'd24;
  assign is_halt = op == 5'd26;
  assign is_multi = is_alu | is_imm | is_ld | is_ldi | is_st | is_mul | is_div |
                    is_neg | is_not | is_br | is_jal;
  // ld/ldi/st/branch fall through to index 0, which is the add the address math needs
  assign alu_idx = is_alu ? 4'(op - 5'd3) : op == 5'd12 ? 4'd2 : op == 5'd13 ? 4'd3 :
                   is_mul ? 4'd8 : is_div ? 4'd9 : is_neg ? 4'd10 : is_not ? 4'd11 : 4'd0;
  assign alu_sel  = 13'd1 << alu_idx;
  assign div_last = cnt_q == CW'(DIV_CYCLES - 1);
  assign run      = state_q != S_RESET && state_q != S_HALT;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_halt ? S_HALT : is_multi ? S_T4 : S_T0;
      S_T4:    state_d = (is_neg | is_not | is_jal) ? S_T0 : is_div ? S_DIV : S_T5;
      S_DIV: begin
        state_d = div_last ? S_T5 : S_DIV;
        cnt_d   = cnt_q + 1'b1;
      end
      S_T5:    state_d = (is_ld | is_st | is_mul | is_div | is_br) ? S_T6 : S_T0;
      S_T6:    state_d = (is_ld | is_st) ? S_T7 : S_T0;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end
  always_comb begin
    {Gra, Grb, Grc, Rin, R_out, BAout} = '0;
    {MDR_rd, MAR_rd, HI_rd, LO_rd, Z_rd, PC_rd, Out_rd, Y_rd, IR_rd, CONin, R15_rd} = '0;
    {MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, Inport_out, C_out} = '0;
    {IncPC, Read, Write, reset_div} = '0;
    op_sel = '0;
    case (state_q)
      S_T0: {PC_out, MAR_rd, IncPC} = '1;
      S_T1: {Read, MDR_rd} = '1;
      S_T2: {MDR_out, IR_rd} = '1;
      S_T3: begin
        if (is_alu | is_imm) {Grb, R_out, Y_rd} = '1;
        if (is_ld | is_ldi | is_st) {Grb, BAout, R_out, Y_rd} = '1;
        if (is_mul | is_div) {Gra, R_out, Y_rd} = '1;
        if (is_neg | is_not) begin
          {Grb, R_out, Z_rd} = '1;
          op_sel = alu_sel;
        end
        if (is_br) {Gra, R_out, CONin} = '1;
        if (is_jr) {Gra, R_out, PC_rd} = '1;
        if (is_jal) {PC_out, R15_rd} = '1;
        if (is_in) {Inport_out, Gra, Rin} = '1;
        if (is_out) {Gra, R_out, Out_rd} = '1;
        if (is_mfhi) {HI_out, Gra, Rin} = '1;
        if (is_mflo) {LO_out, Gra, Rin} = '1;
      end
      S_T4: begin
        if (is_alu) {Grc, R_out, Z_rd} = '1;
        if (is_imm | is_ld | is_ldi | is_st) {C_out, Z_rd} = '1;
        if (is_mul) {Grb, R_out, Z_rd} = '1;
        if (is_div) {Grb, R_out, reset_div} = '1;
        if (is_alu | is_imm | is_ld | is_ldi | is_st | is_mul | is_div) op_sel = alu_sel;
        if (is_neg | is_not) {Zlo_out, Gra, Rin} = '1;
        if (is_br) {PC_out, Y_rd} = '1;
        if (is_jal) {Gra, R_out, PC_rd} = '1;
      end
      S_DIV: begin
        {Grb, R_out} = '1;
        Z_rd   = div_last;
        op_sel = alu_sel;
      end
      S_T5: begin
        if (is_alu | is_imm | is_ldi) {Zlo_out, Gra, Rin} = '1;
        if (is_ld | is_st) {Zlo_out, MAR_rd} = '1;
        if (is_mul | is_div) {Zlo_out, LO_rd} = '1;
        if (is_br) begin
          {C_out, Z_rd} = '1;
          op_sel = alu_sel;
        end
      end
      S_T6: begin
        if (is_ld) {Read, MDR_rd} = '1;
        if (is_st) {Gra, R_out, MDR_rd} = '1;
        if (is_mul | is_div) {Zhi_out, HI_rd} = '1;
        if (is_br && CON_output) {Zlo_out, PC_rd} = '1;
      end
      S_T7: begin
        if (is_ld) {MDR_out, Gra, Rin} = '1;
        if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven cycle-by-cycle check of control_unit outputs.
module tb_control_unit;
  logic clk = 1'b0, clr = 1'b1, con = 1'b0;
  logic [31:0] ir = '0;
  logic Gra, Grb, Grc, Rin, R_out, BAout;
  logic MDR_rd, MAR_rd, HI_rd, LO_rd, Z_rd, PC_rd, Out_rd, Y_rd, IR_rd, CONin, R15_rd;
  logic MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, Inport_out, C_out;
  logic IncPC, Read, Write, reset_div, run;
  logic [12:0] op_sel;
  logic [28:0] ctl;
  int checks = 0, errors = 0;
  localparam logic [28:0] GRA = 29'd1 << 0, GRB = 29'd1 << 1, GRC = 29'd1 << 2,
    RIN = 29'd1 << 3, ROUT = 29'd1 << 4, BAOUT = 29'd1 << 5, MDRRD = 29'd1 << 6,
    MARRD = 29'd1 << 7, HIRD = 29'd1 << 8, LORD = 29'd1 << 9, ZRD = 29'd1 << 10,
    PCRD = 29'd1 << 11, OUTRD = 29'd1 << 12, YRD = 29'd1 << 13, IRRD = 29'd1 << 14,
    CONIN = 29'd1 << 15, R15 = 29'd1 << 16, MDROUT = 29'd1 << 17, HIOUT = 29'd1 << 18,
    LOOUT = 29'd1 << 19, ZHI = 29'd1 << 20, ZLO = 29'd1 << 21, PCOUT = 29'd1 << 22,
    INOUT = 29'd1 << 23, COUT = 29'd1 << 24, INCPC = 29'd1 << 25, READ = 29'd1 << 26,
    WRITE = 29'd1 << 27, RSTDIV = 29'd1 << 28;
  localparam logic [12:0] S_ADD = 13'd1, S_OR = 13'd1 << 3, S_MUL = 13'd1 << 8,
    S_DIV = 13'd1 << 9, S_NOT = 13'd1 << 11;
  localparam logic [31:0] IR_DIV = 32'h7800_0000, IR_HALT = 32'hD000_0000;
  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic [28:0] ctl;
    logic [12:0] sel;
  } vec_t;
  vec_t tbl[$];
  control_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .clr(clr), .IR_contents(ir), .CON_output(con),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .R_out(R_out), .BAout(BAout),
    .MDR_rd(MDR_rd), .MAR_rd(MAR_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .Z_rd(Z_rd),
    .PC_rd(PC_rd), .Out_rd(Out_rd), .Y_rd(Y_rd), .IR_rd(IR_rd), .CONin(CONin),
    .R15_rd(R15_rd), .MDR_out(MDR_out), .HI_out(HI_out), .LO_out(LO_out),
    .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PC_out(PC_out), .Inport_out(Inport_out),
    .C_out(C_out), .IncPC(IncPC), .Read(Read), .Write(Write), .reset_div(reset_div),
    .op_sel(op_sel), .run(run)
  );
  assign ctl = {reset_div, Write, Read, IncPC, C_out, Inport_out, PC_out, Zlo_out, Zhi_out,
                LO_out, HI_out, MDR_out, R15_rd, CONin, IR_rd, Y_rd, Out_rd, PC_rd, Z_rd,
                LO_rd, HI_rd, MAR_rd, MDR_rd, BAout, R_out, Rin, Grc, Grb, Gra};
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [28:0] e_ctl, input logic [12:0] e_sel,
                       input logic e_run);
    checks++;
    if (ctl !== e_ctl || op_sel !== e_sel || run !== e_run) begin
      errors++;
      $display("FAIL %s ctl=%h exp %h op_sel=%h exp %h run=%b exp %b",
               name, ctl, e_ctl, op_sel, e_sel, run, e_run);
    end
  endtask
  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask
  task automatic step(input logic [31:0] i, input logic c);
    @(negedge clk);
    ir  = i;
    con = c;
    #1;
  endtask
  task automatic row(input logic [31:0] i, input logic c, input logic [28:0] k,
                     input logic [12:0] s);
    vec_t v;
    v.ir = i; v.con = c; v.ctl = k; v.sel = s;
    tbl.push_back(v);
  endtask
  task automatic fetch(input logic [31:0] i, input logic c);
    row(i, c, PCOUT | MARRD | INCPC, '0);
    row(i, c, READ | MDRRD, '0);
    row(i, c, MDROUT | IRRD, '0);
  endtask
  function automatic logic [28:0] div_exp(input int r);
    return r == 0 ? PCOUT | MARRD | INCPC : r == 1 ? READ | MDRRD : r == 2 ? MDROUT | IRRD :
           r == 3 ? GRA | ROUT | YRD : r == 4 ? GRB | ROUT | RSTDIV :
           r <= 35 ? GRB | ROUT : r == 36 ? GRB | ROUT | ZRD :
           r == 37 ? ZLO | LORD : ZHI | HIRD;
  endfunction
  initial begin
    int rd_n, z_n, z_at, lo_at, hi_at;
    rd_n = 0; z_n = 0; z_at = -1; lo_at = -1; hi_at = -1;
    fetch(32'h1A92_0000, 0);
    row(32'h1A92_0000, 0, GRB | ROUT | YRD, '0);
    row(32'h1A92_0000, 0, GRC | ROUT | ZRD, S_ADD);
    row(32'h1A92_0000, 0, ZLO | GRA | RIN, '0);
    fetch(32'h6800_0000, 0);
    row(32'h6800_0000, 0, GRB | ROUT | YRD, '0);
    row(32'h6800_0000, 0, COUT | ZRD, S_OR);
    row(32'h6800_0000, 0, ZLO | GRA | RIN, '0);
    fetch(32'h0090_0054, 0);
    row(32'h0090_0054, 0, GRB | BAOUT | ROUT | YRD, '0);
    row(32'h0090_0054, 0, COUT | ZRD, S_ADD);
    row(32'h0090_0054, 0, ZLO | MARRD, '0);
    row(32'h0090_0054, 0, READ | MDRRD, '0);
    row(32'h0090_0054, 0, MDROUT | GRA | RIN, '0);
    fetch(32'h0800_0000, 0);
    row(32'h0800_0000, 0, GRB | BAOUT | ROUT | YRD, '0);
    row(32'h0800_0000, 0, COUT | ZRD, S_ADD);
    row(32'h0800_0000, 0, ZLO | GRA | RIN, '0);
    fetch(32'h1000_0000, 0);
    row(32'h1000_0000, 0, GRB | BAOUT | ROUT | YRD, '0);
    row(32'h1000_0000, 0, COUT | ZRD, S_ADD);
    row(32'h1000_0000, 0, ZLO | MARRD, '0);
    row(32'h1000_0000, 0, GRA | ROUT | MDRRD, '0);
    row(32'h1000_0000, 0, WRITE, '0);
    fetch(32'h7000_0000, 0);
    row(32'h7000_0000, 0, GRA | ROUT | YRD, '0);
    row(32'h7000_0000, 0, GRB | ROUT | ZRD, S_MUL);
    row(32'h7000_0000, 0, ZLO | LORD, '0);
    row(32'h7000_0000, 0, ZHI | HIRD, '0);
    fetch(32'h8800_0000, 0);
    row(32'h8800_0000, 0, GRB | ROUT | ZRD, S_NOT);
    row(32'h8800_0000, 0, ZLO | GRA | RIN, '0);
    for (int t = 1; t >= 0; t--) begin
      fetch(32'h9100_0023, t[0]);
      row(32'h9100_0023, t[0], GRA | ROUT | CONIN, '0);
      row(32'h9100_0023, t[0], PCOUT | YRD, '0);
      row(32'h9100_0023, t[0], COUT | ZRD, S_ADD);
      row(32'h9100_0023, t[0], t[0] ? ZLO | PCRD : '0, '0);
    end
    fetch(32'hA000_0000, 0);
    row(32'hA000_0000, 0, PCOUT | R15, '0);
    row(32'hA000_0000, 0, GRA | ROUT | PCRD, '0);
    fetch(32'h9800_0000, 0);
    row(32'h9800_0000, 0, GRA | ROUT | PCRD, '0);
    fetch(32'hA800_0000, 0);
    row(32'hA800_0000, 0, INOUT | GRA | RIN, '0);
    fetch(32'hB800_0000, 0);
    row(32'hB800_0000, 0, HIOUT | GRA | RIN, '0);
    fetch(32'hC800_0000, 0);
    row(32'hC800_0000, 0, '0, '0);
    fetch(32'hF800_0000, 0);
    row(32'hF800_0000, 0, '0, '0);
    @(negedge clk);
    #1;
    check("reset_state", '0, '0, 1'b0);
    clr = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].ir, tbl[i].con);
      check($sformatf("vec%0d_ir%h", i, tbl[i].ir), tbl[i].ctl, tbl[i].sel, 1'b1);
    end
    for (int c = 0; c < 53; c++) begin
      automatic int r = c % 39;
      step(IR_DIV, 0);
      if (c < 39) begin
        if (reset_div) rd_n++;
        if (Z_rd) begin z_n++; z_at = c; end
        if (LO_rd) lo_at = c;
        if (HI_rd) hi_at = c;
      end
      check($sformatf("div_c%0d", c), div_exp(r), (r >= 4 && r <= 36) ? S_DIV : '0, 1'b1);
    end
    check_int("div_reset_pulses", rd_n, 1);
    check_int("div_z_rd_pulses", z_n, 1);
    check_int("div_z_rd_cycle", z_at, 36);
    check_int("div_lo_rd_cycle", lo_at, 37);
    check_int("div_hi_rd_cycle", hi_at, 38);
    clr = 1'b1;
    step(IR_DIV, 0);
    check("clr_in_div_wait", '0, '0, 1'b0);
    clr = 1'b0;
    step(IR_DIV, 0);
    check("restart_t0", PCOUT | MARRD | INCPC, '0, 1'b1);
    step(IR_HALT, 0);
    check("halt_t1", READ | MDRRD, '0, 1'b1);
    step(IR_HALT, 0);
    check("halt_t2", MDROUT | IRRD, '0, 1'b1);
    step(IR_HALT, 0);
    check("halt_t3", '0, '0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      step(IR_HALT, 0);
      check($sformatf("halt_hold%0d", c), '0, '0, 1'b0);
    end
    clr = 1'b1;
    step(IR_HALT, 0);
    check("halt_clr", '0, '0, 1'b0);
    clr = 1'b0;
    step(32'h1A92_0000, 0);
    check("halt_restart_t0", PCOUT | MARRD | INCPC, '0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control sequencer driving the datapath's control inputs. It reads the instruction register contents and the CON flip-flop result, then steps through fetch and per-opcode execute cycles. It issues the register-select, bus-drive, register-load, ALU-select and memory strobes that the datapath consumes. It is the issuing end of the datapath control interface and sits beside the datapath at the top level, on the same clock.

## Interface
- DIV_CYCLES, 32: cycles the ALU divider needs after `reset_div` before its Z inputs are valid.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-high; the same net as the datapath `clr`.
- IR_contents  in  32  instruction register; opcode = IR_contents[31:27].
- CON_output  in  1  branch condition from the CON flip-flop.
- Gra, Grb, Grc, Rin, R_out, BAout  out  1 each  select-and-encode controls.
- MDR_rd, MAR_rd, HI_rd, LO_rd, Z_rd, PC_rd, Out_rd, Y_rd, IR_rd, CONin, R15_rd  out  1 each  register load enables; R15_rd drives R_rd_diog[15].
- MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, Inport_out, C_out  out  1 each  bus drive enables.
- IncPC, Read, Write, reset_div  out  1 each  PC increment, memory read/write, divider restart.
- op_sel  out  13  one-hot ALU select, bit index by operation:
  - 0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror.
  - 7 rol, 8 mul, 9 div, 10 neg, 11 not.
  - bit 12 is reserved and always 0.
- run  out  1  high while sequencing; low in RESET and HALT.

## Operation
- States: RESET, T0–T7, DIV_WAIT, HALT. Outputs are decoded from the state register and opcode only.
- Any signal not listed as asserted in a step is 0.
- Fetch:
  - T0: PC_out, MAR_rd, IncPC.
  - T1: Read, MDR_rd.
  - T2: MDR_out, IR_rd.
  - T3 decodes IR_contents as loaded at the end of T2.
- Execute steps:
  - add, sub, and, or, shr, shl, ror, rol (opcodes 00011–01010):
    - T3: Grb, R_out, Y_rd.
    - T4: Grc, R_out, op_sel(op), Z_rd.
    - T5: Zlo_out, Gra, Rin.
  - addi, andi, ori (01011–01101): same as above, but T4 uses C_out instead of Grc and R_out; op is add, and or or.
  - ld (00000):
    - T3: Grb, BAout, R_out, Y_rd.
    - T4: C_out, add, Z_rd.
    - T5: Zlo_out, MAR_rd.
    - T6: Read, MDR_rd.
    - T7: MDR_out, Gra, Rin.
  - ldi (00001): T3 and T4 as ld; T5: Zlo_out, Gra, Rin.
  - st (00010): T3–T5 as ld; T6: Gra, R_out, MDR_rd with Read=0; T7: Write.
  - mul (01110):
    - T3: Gra, R_out, Y_rd.
    - T4: Grb, R_out, op_sel mul, Z_rd.
    - T5: Zlo_out, LO_rd.
    - T6: Zhi_out, HI_rd.
  - div (01111):
    - T3 as mul.
    - T4: Grb, R_out, op_sel div, reset_div.
    - DIV_WAIT: Grb, R_out and op_sel div held for DIV_CYCLES cycles; Z_rd only on the last of them.
    - Then T5 and T6 as mul.
  - neg, not (10000, 10001): T3: Grb, R_out, op_sel, Z_rd; T4: Zlo_out, Gra, Rin.
  - branch (10010):
    - T3: Gra, R_out, CONin.
    - T4: PC_out, Y_rd.
    - T5: C_out, add, Z_rd.
    - T6: Zlo_out and PC_rd only if CON_output=1; otherwise an idle step.
  - jr (10011): T3: Gra, R_out, PC_rd.
  - jal (10100): T3: PC_out, R15_rd; T4: Gra, R_out, PC_rd.
  - in (10101): T3: Inport_out, Gra, Rin.
  - out (10110): T3: Gra, R_out, Out_rd.
  - mfhi (10111): T3: HI_out, Gra, Rin. mflo (11000): T3: LO_out, Gra, Rin.
  - nop (11001): no execute step.
  - halt (11010): T3 → HALT.
  - Opcodes 11011–11111 execute as nop.
- After an instruction's last listed step, the next state is T0. nop and undefined opcodes go T3 → T0 with all outputs 0 in T3.

## Timing
- clr=1 at an edge → RESET at any state, including mid-instruction or DIV_WAIT.
  - The in-flight instruction is abandoned; no partial writes after that edge.
  - Every output is 0 in RESET; run=0.
- RESET → T0 on the first edge with clr=0; run=1 from T0 onward.
- Cycle counts, fetch included:
  - 3-register and immediate ALU ops: 6.
  - ld, st: 8. ldi: 6. neg, not: 5. mul: 7. div: 7+DIV_CYCLES.
  - branch: 7, taken or not. jal: 5. jr, in, out, mfhi, mflo: 4. nop: 4.
- HALT holds all outputs 0 with run=0 and leaves only on clr.
- CON_output is sampled in T6, three cycles after CONin, so the flip-flop is always settled.
- IR_contents is treated as stable from T3 until the next T2; the block does not latch it.
- reset_div is high for exactly one cycle per div.

## Test plan
- Reset: assert clr during DIV_WAIT → next cycle all outputs 0 and run=0; release clr → the next cycle is T0 with PC_out=MAR_rd=IncPC=1.
- add r5,r2,r4 (IR=0x1A920000): T0–T5 match the add sequence exactly; op_sel=13'h0001 only in T4; the 7th cycle is T0.
- ld r1,0x54(r2) (IR=0x00900054): Read=1 only in T1 and T6; Gra and Rin in T7; 8 cycles total.
- Branch IR=0x91000023:
  - CON_output=1 in T6 → PC_rd=1 with Zlo_out=1.
  - CON_output=0 → PC_rd stays 0.
- div with DIV_CYCLES=32: reset_div high one cycle; Z_rd high exactly once, 32 cycles after T4; LO_rd then HI_rd follow; 39 cycles total.
- halt (IR=0xD0000000) → run falls after T3 and outputs stay 0 for 100 cycles; clr → restart at T0.
